// File: rtl/parking_sensor_frontend.sv
// Parking-lot gate front end: per-channel sync/debounce of the IR sensors,
// free-slot bookkeeping, and the admission FSM driving the gate request.

module psf_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreeing cycle restarts the qualification window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
endmodule

module parking_sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int COUNT_W         = 8
) (
    input  logic               clock_50MHz,
    input  logic               reset,
    input  logic [5:0]         slot_ir_n,
    input  logic               gate_ir_n,
    output logic               position_1,
    output logic               position_2,
    output logic               position_3,
    output logic               position_4,
    output logic               position_5,
    output logic               position_6,
    output logic [2:0]         free_count,
    output logic               lot_full,
    output logic               gate_request_n,
    output logic               reject,
    output logic [COUNT_W-1:0] entry_count
);
    localparam int NUM_CH = 7;
    localparam int HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADMIT,
        S_HOLD,
        S_REJECT
    } state_t;

    logic [NUM_CH-1:0] raw_all, stable_all;
    logic [5:0]        slot_free;
    logic              car_present;

    assign raw_all = {gate_ir_n, slot_ir_n};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_deb
        psf_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i   (clock_50MHz),
            .rst_i   (reset),
            .raw_i   (raw_all[ch]),
            .stable_o(stable_all[ch])
        );
    end

    assign slot_free   = stable_all[5:0];
    assign car_present = ~stable_all[6];

    logic [2:0] free_cnt_d, free_cnt_q;
    logic       lot_full_q;

    always_comb begin
        free_cnt_d = '0;
        for (int i = 0; i < 6; i++) begin
            free_cnt_d = free_cnt_d + {2'b00, slot_free[i]};
        end
    end

    always_ff @(posedge clock_50MHz) begin
        if (reset) begin
            free_cnt_q <= 3'd6;
            lot_full_q <= 1'b0;
        end else begin
            free_cnt_q <= free_cnt_d;
            lot_full_q <= (free_cnt_d == 3'd0);
        end
    end

    state_t             state_q, state_d;
    logic [HW-1:0]      timer_q, timer_d;
    logic [COUNT_W-1:0] entry_q, entry_d;
    logic               greq_n_q, greq_n_d;
    logic               reject_q, reject_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        entry_d = entry_q;
        case (state_q)
            S_IDLE: begin
                if (car_present) begin
                    state_d = (free_cnt_q != 3'd0) ? S_ADMIT : S_REJECT;
                end
            end
            S_ADMIT: begin
                if (!car_present) begin
                    state_d = S_HOLD;
                    timer_d = HOLD_LAST;
                end
            end
            S_HOLD: begin
                // A returning car takes priority over an expiring timer.
                if (car_present) begin
                    state_d = S_ADMIT;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                    if (entry_q != '1) begin
                        entry_d = entry_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_REJECT: begin
                if (!car_present) begin
                    state_d = S_IDLE;
                end else if (free_cnt_q != 3'd0) begin
                    state_d = S_ADMIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        greq_n_d = !((state_d == S_ADMIT) || (state_d == S_HOLD));
        reject_d = (state_d == S_REJECT);
    end

    always_ff @(posedge clock_50MHz) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            entry_q  <= '0;
            greq_n_q <= 1'b1;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            entry_q  <= entry_d;
            greq_n_q <= greq_n_d;
            reject_q <= reject_d;
        end
    end

    assign position_1     = slot_free[0];
    assign position_2     = slot_free[1];
    assign position_3     = slot_free[2];
    assign position_4     = slot_free[3];
    assign position_5     = slot_free[4];
    assign position_6     = slot_free[5];
    assign free_count     = free_cnt_q;
    assign lot_full       = lot_full_q;
    assign gate_request_n = greq_n_q;
    assign reject         = reject_q;
    assign entry_count    = entry_q;
endmodule

// File: tb/tb_parking_sensor_frontend.sv
module tb_parking_sensor_frontend;
    localparam int SIG_POS  = 0;
    localparam int SIG_FC   = 1;
    localparam int SIG_FULL = 2;
    localparam int SIG_GREQ = 3;
    localparam int SIG_REJ  = 4;
    localparam int SIG_ENT  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] slot_ir_n;
    logic       gate_ir_n;
    logic       p1, p2, p3, p4, p5, p6;
    logic [2:0] free_count;
    logic       lot_full, gate_request_n, reject;
    logic [7:0] entry_count;

    parking_sensor_frontend #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .COUNT_W        (8)
    ) dut (
        .clock_50MHz   (clk),
        .reset         (reset),
        .slot_ir_n     (slot_ir_n),
        .gate_ir_n     (gate_ir_n),
        .position_1    (p1),
        .position_2    (p2),
        .position_3    (p3),
        .position_4    (p4),
        .position_5    (p5),
        .position_6    (p6),
        .free_count    (free_count),
        .lot_full      (lot_full),
        .gate_request_n(gate_request_n),
        .reject        (reject),
        .entry_count   (entry_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        int         sig;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic expect_at(input int at, input int sig, input logic [7:0] val, input string nm);
        exp_t e;
        e.at = at; e.sig = sig; e.val = val; e.nm = nm;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] sig_val(input int s);
        case (s)
            SIG_POS:  return {2'b00, p6, p5, p4, p3, p2, p1};
            SIG_FC:   return {5'b0, free_count};
            SIG_FULL: return {7'b0, lot_full};
            SIG_GREQ: return {7'b0, gate_request_n};
            SIG_REJ:  return {7'b0, reject};
            default:  return entry_count;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                logic [7:0] act;
                act = sig_val(sb[i].sig);
                n_cmp++;
                if (sb[i].at < cyc || act !== sb[i].val) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", sb[i].nm, sb[i].at, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int k0, k1, k2, k3;

    initial begin
        reset     = 1'b1;
        slot_ir_n = 6'h3F;
        gate_ir_n = 1'b1;
        expect_at(2, SIG_POS,  8'h3F, "rst_pos");
        expect_at(2, SIG_FC,   8'd6,  "rst_fc");
        expect_at(2, SIG_FULL, 8'd0,  "rst_full");
        expect_at(2, SIG_GREQ, 8'd1,  "rst_greq");
        expect_at(2, SIG_REJ,  8'd0,  "rst_rej");
        expect_at(2, SIG_ENT,  8'd0,  "rst_ent");
        tick(3);
        reset = 1'b0;

        k0 = cyc; slot_ir_n = 6'b111110;
        expect_at(k0 + 5, SIG_POS, 8'h3F, "t1_pos_before");
        expect_at(k0 + 6, SIG_POS, 8'h3E, "t1_pos_edge6");
        expect_at(k0 + 6, SIG_FC,  8'd6,  "t1_fc_edge6");
        expect_at(k0 + 7, SIG_FC,  8'd5,  "t1_fc_edge7");
        expect_at(k0 + 7, SIG_FULL, 8'd0, "t1_full");
        tick(10);
        k0 = cyc; slot_ir_n = 6'h3F;
        expect_at(k0 + 7, SIG_FC, 8'd6, "t1_fc_restore");
        tick(10);

        k0 = cyc; slot_ir_n = 6'b111110;
        tick(3);
        slot_ir_n = 6'h3F;
        expect_at(k0 + 6, SIG_POS, 8'h3F, "t2_pos_a");
        expect_at(k0 + 8, SIG_POS, 8'h3F, "t2_pos_b");
        expect_at(k0 + 9, SIG_FC,  8'd6,  "t2_fc");
        tick(12);

        k0 = cyc; gate_ir_n = 1'b0;
        expect_at(k0 + 6, SIG_GREQ, 8'd1, "t3_greq_pre");
        expect_at(k0 + 7, SIG_GREQ, 8'd0, "t3_greq_open");
        tick(20);
        k1 = cyc; gate_ir_n = 1'b1;
        expect_at(k1 + 14, SIG_GREQ, 8'd0, "t3_greq_hold_end");
        expect_at(k1 + 15, SIG_GREQ, 8'd1, "t3_greq_close");
        expect_at(k1 + 14, SIG_ENT,  8'd0, "t3_ent_pre");
        expect_at(k1 + 15, SIG_ENT,  8'd1, "t3_ent_post");
        tick(20);

        k0 = cyc; gate_ir_n = 1'b0;
        tick(10);
        k1 = cyc; gate_ir_n = 1'b1;
        tick(5);
        gate_ir_n = 1'b0;
        expect_at(k1 + 12, SIG_GREQ, 8'd0, "t5_greq_rebreak");
        expect_at(k1 + 13, SIG_GREQ, 8'd0, "t5_greq_admit");
        expect_at(k1 + 13, SIG_ENT,  8'd1, "t5_ent_hold");
        tick(10);
        k3 = cyc; gate_ir_n = 1'b1;
        expect_at(k3 + 14, SIG_GREQ, 8'd0, "t5_greq_hold_end");
        expect_at(k3 + 15, SIG_GREQ, 8'd1, "t5_greq_close");
        expect_at(k3 + 14, SIG_ENT,  8'd1, "t5_ent_pre");
        expect_at(k3 + 15, SIG_ENT,  8'd2, "t5_ent_post");
        tick(20);

        k0 = cyc; slot_ir_n = 6'b000000;
        expect_at(k0 + 6, SIG_POS,  8'h00, "t4_pos_full");
        expect_at(k0 + 7, SIG_FC,   8'd0,  "t4_fc_zero");
        expect_at(k0 + 7, SIG_FULL, 8'd1,  "t4_full");
        tick(10);
        k1 = cyc; gate_ir_n = 1'b0;
        expect_at(k1 + 6, SIG_REJ,  8'd0, "t4_rej_pre");
        expect_at(k1 + 7, SIG_REJ,  8'd1, "t4_rej");
        expect_at(k1 + 7, SIG_GREQ, 8'd1, "t4_greq_shut");
        tick(10);
        k2 = cyc; slot_ir_n = 6'b000100;
        expect_at(k2 + 6, SIG_POS,  8'h04, "t4_pos_slot3");
        expect_at(k2 + 7, SIG_FC,   8'd1,  "t4_fc_one");
        expect_at(k2 + 7, SIG_FULL, 8'd0,  "t4_full_clr");
        expect_at(k2 + 7, SIG_REJ,  8'd1,  "t4_rej_still");
        expect_at(k2 + 8, SIG_REJ,  8'd0,  "t4_rej_clr");
        expect_at(k2 + 8, SIG_GREQ, 8'd0,  "t4_greq_open");
        tick(10);
        k3 = cyc; gate_ir_n = 1'b1;
        expect_at(k3 + 15, SIG_GREQ, 8'd1, "t4_greq_close");
        expect_at(k3 + 15, SIG_ENT,  8'd3, "t4_ent");
        tick(20);

        slot_ir_n = 6'h3F;
        tick(10);
        k0 = cyc; gate_ir_n = 1'b0;
        tick(10);
        k1 = cyc; gate_ir_n = 1'b1;
        tick(8);
        slot_ir_n = 6'b000000;
        tick(2);
        reset = 1'b1; slot_ir_n = 6'h3F;
        expect_at(k1 + 10, SIG_GREQ, 8'd0,  "t6_greq_inhold");
        expect_at(k1 + 11, SIG_GREQ, 8'd1,  "t6_greq_rst");
        expect_at(k1 + 11, SIG_ENT,  8'd0,  "t6_ent_rst");
        expect_at(k1 + 11, SIG_POS,  8'h3F, "t6_pos_rst");
        expect_at(k1 + 11, SIG_FC,   8'd6,  "t6_fc_rst");
        tick(2);
        reset = 1'b0;
        expect_at(k1 + 16, SIG_POS,  8'h3F, "t6_pos_after");
        expect_at(k1 + 16, SIG_GREQ, 8'd1,  "t6_greq_after");
        expect_at(k1 + 16, SIG_ENT,  8'd0,  "t6_ent_after");
        tick(6);

        for (int i = 0; i < 300; i++) begin
            k0 = cyc; gate_ir_n = 1'b0;
            expect_at(k0 + 24, SIG_ENT, (i + 1 >= 255) ? 8'd255 : 8'(i + 1), "sat_ent");
            tick(8);
            gate_ir_n = 1'b1;
            tick(18);
        end

        tick(20);
        n_cmp++;
        if (entry_count !== 8'd255) begin
            n_err++;
            $display("FAIL end_ent: got 0x%0h, expected 0xff", entry_count);
        end
        n_cmp++;
        if (gate_request_n !== 1'b1) begin
            n_err++;
            $display("FAIL end_greq: got %b, expected 1", gate_request_n);
        end
        n_cmp++;
        if (reject !== 1'b0) begin
            n_err++;
            $display("FAIL end_rej: got %b, expected 0", reject);
        end
        n_cmp++;
        if (free_count !== 3'd6) begin
            n_err++;
            $display("FAIL end_fc: got %0d, expected 6", free_count);
        end
        n_cmp++;
        if (lot_full !== 1'b0) begin
            n_err++;
            $display("FAIL end_full: got %b, expected 0", lot_full);
        end
        n_cmp++;
        if ({p6, p5, p4, p3, p2, p1} !== 6'h3F) begin
            n_err++;
            $display("FAIL end_pos: got 0x%0h, expected 0x3f", {p6, p5, p4, p3, p2, p1});
        end

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s @cyc %0d: got no sample, expected 0x%0h", sb[0].nm, sb[0].at, sb[0].val);
            sb.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/parking_sensor_frontend.md
Name: parking_sensor_frontend

Overview:
Upstream conditioning stage for the parking-lot gate servo controller. Synchronises and debounces the six per-slot IR sensors and the gate IR sensor, and publishes clean slot-free flags position_1..position_6. Runs an admission state machine that drives the controller's active-low infrared input (gate_request_n), and keeps the free-slot count, lot-full flag and entry statistics.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive clock_50MHz cycles a synchronised input must differ from its stable level before the new level is accepted (10 ms).
HOLD_CYCLES, 50000000, cycles the gate request is held after the car clears the gate beam (1 s).
COUNT_W, 8, width of entry_count.

Ports:
clock_50MHz  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
slot_ir_n  input  6  raw slot sensors; bit k low = car in slot k+1; asynchronous to the clock.
gate_ir_n  input  1  raw gate-entry IR; low = car at gate; asynchronous.
position_1..position_6  output  1 each  debounced slot flags; 1 = slot free.
free_count  output  3  number of free slots, 0..6.
lot_full  output  1  1 when free_count == 0.
gate_request_n  output  1  active-low request to the gate controller's infrared input; low = open gate.
reject  output  1  high while a car waits at the gate with the lot full.
entry_count  output  COUNT_W  completed admissions; saturates at all-ones.

Behaviour:
- Reset, sampled at clock edge, dominates everything. After reset: all sync flops and stable levels = 1; position_1..6 = 1; free_count = 6; lot_full = 0; gate_request_n = 1; reject = 0; entry_count = 0; FSM = IDLE; all counters = 0.
- Synchroniser: two flops per channel (7 channels).
- Debounce, per channel: if the synchronised value equals the stable level, clear the counter. Otherwise increment the counter. On the DEBOUNCE_CYCLES-th consecutive differing cycle, load the stable level and clear the counter.
- Debounce latency: a raw change held steady updates the stable level at rising edge 2+DEBOUNCE_CYCLES. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never propagates.
- Counter width: $clog2(DEBOUNCE_CYCLES+1).
- position_k = stable slot level of bit k-1 (1 = free).
- free_count and lot_full are registered from the stable levels, one cycle after them. free_count = popcount, 3-bit, no overflow possible.
- car_present = NOT (stable gate level).
- FSM states: IDLE, ADMIT, HOLD, REJECT.
  - IDLE: gate_request_n = 1, reject = 0. If car_present and free_count != 0, go to ADMIT. If car_present and free_count == 0, go to REJECT.
  - ADMIT: gate_request_n = 0. When car_present drops, go to HOLD and load hold_timer = HOLD_CYCLES-1. The lot becoming full while in ADMIT does not abort it (admission is committed).
  - HOLD: gate_request_n = 0; hold_timer decrements each cycle. If car_present reasserts, return to ADMIT (the timer reloads on the next exit). When hold_timer == 0 and no car is present, go to IDLE and increment entry_count, saturating at all-ones. car_present and timer==0 in the same cycle: car wins, go to ADMIT, no increment.
  - REJECT: reject = 1, gate_request_n = 1. If car_present drops, go to IDLE. If a slot frees while the car is still present (free_count != 0), go to ADMIT with reject = 0.
- gate_request_n and reject are registered FSM outputs: they change on the same edge as the state register.
- Reset mid-HOLD or mid-debounce abandons the operation: gate_request_n = 1 next cycle, no entry_count increment.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
1. Reset, then slot_ir_n=6'b111110 held -> position_1 falls at edge 6, free_count=5 at edge 7; position_2..6 stay 1.
2. slot_ir_n[0] low pulse of 3 cycles -> position_1 never leaves 1; free_count stays 6.
3. gate_ir_n low 20 cycles, lot not full -> gate_request_n=0 one cycle after car_present. After gate_ir_n returns high, gate_request_n stays 0 for 8 cycles past the debounced release, then returns to 1; entry_count 0->1.
4. All slots occupied (free_count=0, lot_full=1), gate_ir_n low -> reject=1, gate_request_n stays 1. Free slot 3 while the car waits -> reject=0, gate_request_n=0.
5. Car re-breaks the beam during HOLD (hold_timer=3) -> back to ADMIT, gate_request_n stays 0, entry_count unchanged until the final clear plus 8 cycles.
6. Assert reset during HOLD -> gate_request_n=1 next cycle, entry_count=0, position_1..6=1; entry_count saturates at 255 after 300 admissions with COUNT_W=8.
